// File: rtl/issue_queue.sv
// ----------------------------------------------------------------------------
// issue_queue
//   Collapsing, age-ordered issue queue. Slot 0 holds the oldest entry and the
//   valid slots are exactly 0..count-1. Each cycle the oldest entry whose two
//   source operands are ready is presented on the issue port. When it is
//   accepted, every younger entry shifts down one slot. Writeback broadcasts
//   wake waiting sources. A broadcast in the same cycle as an enqueue is
//   bypassed into the new entry's ready bits.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid / in_ready   enqueue handshake (in_ready = count < DEPTH)
//   in_rs/rt_phys, _rdy   source tags and their busy-table ready state
//   in_payload            opaque payload, carried unmodified
//   wb_valid, wb_phys     writeback wakeup broadcast
//   issue_valid/_ready    issue handshake; issue_* show the selected entry
//   flush                 squash all entries
//   count                 registered number of valid entries
// ----------------------------------------------------------------------------
module issue_queue #(
    parameter int DEPTH     = 16,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PREG_W-1:0]          in_rs_phys,
    input  logic [PREG_W-1:0]          in_rt_phys,
    input  logic                       in_rs_rdy,
    input  logic                       in_rt_rdy,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    input  logic                       wb_valid,
    input  logic [PREG_W-1:0]          wb_phys,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [PREG_W-1:0]          issue_rs_phys,
    output logic [PREG_W-1:0]          issue_rt_phys,
    output logic [PAYLOAD_W-1:0]       issue_payload,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [PREG_W-1:0]    rs_phys;
        logic [PREG_W-1:0]    rt_phys;
        logic                 rs_rdy;
        logic                 rt_rdy;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t            ent_r     [DEPTH];
    entry_t            shift_s   [DEPTH];
    entry_t            ent_nxt_s [DEPTH];
    entry_t            in_ent_s;
    entry_t            sel_ent_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [CNT_W-1:0]  live_cnt_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic              sel_found_s;
    logic              issue_fire_s;
    logic              enq_fire_s;

    assign in_ready     = (count_r < CNT_W'(DEPTH));
    assign count        = count_r;
    assign issue_fire_s = sel_found_s & issue_ready & ~flush;
    assign enq_fire_s   = in_valid & in_ready & ~flush;
    // Entries that survive this edge's dequeue; the new entry lands right after them.
    assign live_cnt_s   = count_r - {{(CNT_W-1){1'b0}}, issue_fire_s};

    // Oldest-ready select: scan from the top so the lowest matching slot wins.
    always_comb begin
        logic hit;
        sel_found_s = 1'b0;
        sel_idx_s   = {IDX_W{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hit         = (CNT_W'(i) < count_r) && ent_r[i].rs_rdy && ent_r[i].rt_rdy;
            sel_found_s = sel_found_s | hit;
            sel_idx_s   = hit ? IDX_W'(i) : sel_idx_s;
        end
    end

    // Present the selected entry, or all zeros when nothing is ready.
    always_comb begin
        sel_ent_s     = ent_r[sel_idx_s];
        issue_valid   = sel_found_s;
        issue_rs_phys = sel_found_s ? sel_ent_s.rs_phys : {PREG_W{1'b0}};
        issue_rt_phys = sel_found_s ? sel_ent_s.rt_phys : {PREG_W{1'b0}};
        issue_payload = sel_found_s ? sel_ent_s.payload : {PAYLOAD_W{1'b0}};
    end

    // Incoming entry with same-cycle writeback folded into its ready bits.
    always_comb begin
        in_ent_s.rs_phys = in_rs_phys;
        in_ent_s.rt_phys = in_rt_phys;
        in_ent_s.rs_rdy  = in_rs_rdy | (wb_valid & (wb_phys == in_rs_phys));
        in_ent_s.rt_rdy  = in_rt_rdy | (wb_valid & (wb_phys == in_rt_phys));
        in_ent_s.payload = in_payload;
    end

    // Collapse: slots at or above the issued slot take their upper neighbour.
    always_comb begin
        logic run;
        run = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            run        = run | (sel_idx_s == IDX_W'(i));
            shift_s[i] = (run && issue_fire_s) ? ent_r[i + 1] : ent_r[i];
        end
        // The top slot is never valid after a shift, so it simply holds.
        shift_s[DEPTH-1] = ent_r[DEPTH-1];
    end

    // Wakeup on the shifted image, then drop the new entry into the first free slot.
    always_comb begin
        logic wake_ok;
        for (int i = 0; i < DEPTH; i++) begin
            wake_ok              = wb_valid && (CNT_W'(i) < live_cnt_s);
            ent_nxt_s[i]         = shift_s[i];
            ent_nxt_s[i].rs_rdy  = shift_s[i].rs_rdy | (wake_ok & (shift_s[i].rs_phys == wb_phys));
            ent_nxt_s[i].rt_rdy  = shift_s[i].rt_rdy | (wake_ok & (shift_s[i].rt_phys == wb_phys));
            ent_nxt_s[i]         = (enq_fire_s && (CNT_W'(i) == live_cnt_s)) ? in_ent_s : ent_nxt_s[i];
        end
        count_nxt_s = live_cnt_s + {{(CNT_W-1){1'b0}}, enq_fire_s};
    end

    // State register; reset and flush both empty the queue and clear every ready bit.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= '0;
            end
        end else begin
            count_r <= count_nxt_s;
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= ent_nxt_s[i];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// ----------------------------------------------------------------------------
// tb_issue_queue
//   Directed and short pseudo-random stimulus for issue_queue. A queue-based
//   reference model (oldest-ready pick, delete, wake, push) is compared with
//   the DUT on every falling edge. Literal expectations at key points pin the
//   model itself.
// ----------------------------------------------------------------------------
module tb_issue_queue;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_rs_phys;
    logic [5:0]  in_rt_phys;
    logic        in_rs_rdy;
    logic        in_rt_rdy;
    logic [63:0] in_payload;
    logic        wb_valid;
    logic [5:0]  wb_phys;
    logic        issue_valid;
    logic        issue_ready;
    logic [5:0]  issue_rs_phys;
    logic [5:0]  issue_rt_phys;
    logic [63:0] issue_payload;
    logic        flush;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    typedef struct {
        logic [5:0]  rs;
        logic [5:0]  rt;
        bit          rsr;
        bit          rtr;
        logic [63:0] pl;
    } m_ent_t;

    m_ent_t mq[$];

    issue_queue #(.DEPTH(16), .PREG_W(6), .PAYLOAD_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_phys(in_rs_phys), .in_rt_phys(in_rt_phys),
        .in_rs_rdy(in_rs_rdy), .in_rt_rdy(in_rt_rdy),
        .in_payload(in_payload),
        .wb_valid(wb_valid), .wb_phys(wb_phys),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs_phys(issue_rs_phys), .issue_rt_phys(issue_rt_phys),
        .issue_payload(issue_payload),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_sel();
        for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].rsr && mq[k].rtr) return k;
        end
        return -1;
    endfunction

    // Reference model step, applied with the inputs present at the rising edge.
    task automatic model_step();
        int     s;
        bit     enq_ok;
        m_ent_t e;
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            enq_ok = in_valid && (mq.size() < DEPTH);
            s = m_sel();
            if (s >= 0 && issue_ready) mq.delete(s);
            if (wb_valid) begin
                for (int k = 0; k < mq.size(); k++) begin
                    e = mq[k];
                    if (e.rs == wb_phys) e.rsr = 1'b1;
                    if (e.rt == wb_phys) e.rtr = 1'b1;
                    mq[k] = e;
                end
            end
            if (enq_ok) begin
                e.rs  = in_rs_phys;
                e.rt  = in_rt_phys;
                e.rsr = in_rs_rdy || (wb_valid && wb_phys == in_rs_phys);
                e.rtr = in_rt_rdy || (wb_valid && wb_phys == in_rt_phys);
                e.pl  = in_payload;
                mq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic enq(input logic [5:0] rs, input logic rsr, input logic [5:0] rt,
                       input logic rtr, input logic [63:0] pl);
        in_valid   = 1'b1;
        in_rs_phys = rs;
        in_rs_rdy  = rsr;
        in_rt_phys = rt;
        in_rt_rdy  = rtr;
        in_payload = pl;
    endtask

    task automatic wb(input logic v, input logic [5:0] p);
        wb_valid = v;
        wb_phys  = p;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        int s;
        forever begin
            @(negedge clk);
            if (started) begin
                s = m_sel();
                chk("issue_valid", 64'(issue_valid), 64'(s >= 0));
                if (s >= 0) begin
                    chk("issue_rs_phys", 64'(issue_rs_phys), 64'(mq[s].rs));
                    chk("issue_rt_phys", 64'(issue_rt_phys), 64'(mq[s].rt));
                    chk("issue_payload", issue_payload, mq[s].pl);
                end else begin
                    chk("issue_rs_phys_idle", 64'(issue_rs_phys), 64'd0);
                    chk("issue_rt_phys_idle", 64'(issue_rt_phys), 64'd0);
                    chk("issue_payload_idle", issue_payload, 64'd0);
                end
                chk("count", 64'(count), 64'(mq.size()));
                chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rs_phys = 6'd0; in_rt_phys = 6'd0;
        in_rs_rdy = 1'b0; in_rt_rdy = 1'b0; in_payload = 64'd0;
        wb_valid = 1'b0; wb_phys = 6'd0; issue_ready = 1'b0; flush = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        started = 1'b1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_issue_valid", 64'(issue_valid), 64'd0);
        chk("reset_payload", issue_payload, 64'd0);

        // Single ready entry issues the cycle after enqueue.
        issue_ready = 1'b1;
        enq(6'd5, 1'b1, 6'd6, 1'b1, 64'hA);
        tick();
        in_valid = 1'b0;
        chk("a_count1", 64'(count), 64'd1);
        chk("a_valid", 64'(issue_valid), 64'd1);
        chk("a_payload", issue_payload, 64'hA);
        tick();
        chk("a_count0", 64'(count), 64'd0);

        // Younger ready entry overtakes an older waiting one.
        enq(6'd9, 1'b0, 6'd1, 1'b1, 64'hA1);
        tick();
        chk("b_a_waiting", 64'(issue_valid), 64'd0);
        enq(6'd2, 1'b1, 6'd3, 1'b1, 64'hB1);
        tick();
        in_valid = 1'b0;
        chk("b_first", issue_payload, 64'hB1);
        wb(1'b1, 6'd9);
        tick();
        wb(1'b0, 6'd0);
        chk("b_a_after_wake", issue_payload, 64'hA1);
        chk("b_count1", 64'(count), 64'd1);
        tick();
        chk("b_count0", 64'(count), 64'd0);

        // Writeback bypass into the entry being enqueued.
        enq(6'd12, 1'b0, 6'd4, 1'b1, 64'hC1);
        wb(1'b1, 6'd12);
        tick();
        in_valid = 1'b0;
        wb(1'b0, 6'd0);
        chk("c_bypass_valid", 64'(issue_valid), 64'd1);
        chk("c_payload", issue_payload, 64'hC1);
        tick();

        // Fill to capacity, overflow ignored, middle issue collapses the queue.
        issue_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            enq(6'(20 + i), 1'b0, 6'd1, 1'b1, 64'h100 + 64'(i));
            tick();
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'd16);
        enq(6'd60, 1'b1, 6'd61, 1'b1, 64'hDEAD);
        tick();
        in_valid = 1'b0;
        chk("full_ignore_count", 64'(count), 64'd16);
        chk("full_ignore_valid", 64'(issue_valid), 64'd0);
        wb(1'b1, 6'd27);
        tick();
        wb(1'b0, 6'd0);
        chk("slot7_payload", issue_payload, 64'h107);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("after_issue_count", 64'(count), 64'd15);
        chk("after_issue_in_ready", 64'(in_ready), 64'd1);
        wb(1'b1, 6'd28);
        tick();
        wb(1'b0, 6'd0);
        chk("shifted_payload", issue_payload, 64'h108);
        chk("shifted_rs", 64'(issue_rs_phys), 64'd28);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_count", 64'(count), 64'd0);

        // Enqueue and issue on the same edge at count 4.
        for (int i = 0; i < 4; i++) begin
            enq(6'(40 + i), 1'b0, 6'd1, 1'b1, 64'h200 + 64'(i));
            tick();
        end
        in_valid = 1'b0;
        wb(1'b1, 6'd41);
        tick();
        wb(1'b0, 6'd0);
        chk("c4_payload", issue_payload, 64'h201);
        enq(6'd50, 1'b0, 6'd1, 1'b1, 64'h2D0);
        issue_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("c4_count_same", 64'(count), 64'd4);
        chk("c4_none_ready", 64'(issue_valid), 64'd0);
        wb(1'b1, 6'd50);
        tick();
        wb(1'b0, 6'd0);
        chk("c4_new_entry", issue_payload, 64'h2D0);
        chk("c4_new_rs", 64'(issue_rs_phys), 64'd50);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Flush, then reset, with every other control asserted.
        for (int pass = 0; pass < 2; pass++) begin
            issue_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
                enq(6'(i), 1'b1, 6'(i), 1'b1, 64'h300 + 64'(i));
                tick();
            end
            chk("ten_count", 64'(count), 64'd10);
            enq(6'd7, 1'b1, 6'd8, 1'b1, 64'h3FF);
            issue_ready = 1'b1;
            wb(1'b1, 6'd5);
            if (pass == 0) flush = 1'b1;
            else           rst_n = 1'b0;
            tick();
            flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
            wb(1'b0, 6'd0);
            chk("squash_count", 64'(count), 64'd0);
            chk("squash_valid", 64'(issue_valid), 64'd0);
            chk("squash_payload", issue_payload, 64'd0);
            chk("squash_in_ready", 64'(in_ready), 64'd1);
        end

        // Mixed traffic on a small tag space to exercise wakeups and collapses.
        for (int c = 0; c < 400; c++) begin
            in_valid    = 1'($urandom_range(0, 1));
            in_rs_phys  = 6'($urandom_range(0, 7));
            in_rt_phys  = 6'($urandom_range(0, 7));
            in_rs_rdy   = ($urandom_range(0, 3) == 0);
            in_rt_rdy   = ($urandom_range(0, 1) == 0);
            in_payload  = {32'($urandom), 32'($urandom)};
            wb_valid    = 1'($urandom_range(0, 1));
            wb_phys     = 6'($urandom_range(0, 7));
            issue_ready = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 60) == 0);
            tick();
        end
        in_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0; issue_ready = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
